// File: rtl/trdb_cfg_master.sv
// Command-to-bus initiator for the trace debugger register port: write, read, poll-until-clear.
// Optional transfer counter on txn_count_o when TRDB_CFG_MASTER_STATS_EN is defined.
module trdb_cfg_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int POLL_MAX       = 256,
    parameter int POLL_GAP       = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_timeout_o,
    output logic                      per_valid_o,
    output logic                      per_we_o,
    output logic [APB_ADDR_WIDTH-1:0] per_addr_o,
    output logic [31:0]               per_wdata_o,
    input  logic                      per_ready_i,
    input  logic [31:0]               per_rdata_i,
    output logic                      busy_o,
    output logic [15:0]               txn_count_o
);

    localparam int PW = $clog2(POLL_MAX) + 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, GAP, RESP} state_t;

    state_t        state;
    logic [1:0]    op;
    logic [31:0]   mask;
    logic [PW-1:0] poll_cnt;
    logic [GW-1:0] gap_cnt;

    logic is_poll;
    logic clear;
    logic poll_again;

    assign is_poll    = (op == OP_POLL);
    assign clear      = ((per_rdata_i & mask) == 32'h0);
    assign poll_again = is_poll && !clear && (poll_cnt != POLL_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            op            <= OP_WR;
            mask          <= '0;
            poll_cnt      <= '0;
            gap_cnt       <= '0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
            per_valid_o   <= 1'b0;
            per_we_o      <= 1'b0;
            per_addr_o    <= '0;
            per_wdata_o   <= '0;
            busy_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op          <= cmd_op_i;
                        mask        <= cmd_wdata_i;
                        poll_cnt    <= '0;
                        per_addr_o  <= cmd_addr_i;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (cmd_op_i == 2'b11) begin
                            state         <= RESP;
                            rsp_valid_o   <= 1'b1;
                            rsp_rdata_o   <= '0;
                            rsp_timeout_o <= 1'b1;
                        end else begin
                            state       <= ACCESS;
                            per_valid_o <= 1'b1;
                            per_we_o    <= (cmd_op_i == OP_WR);
                            per_wdata_o <= (cmd_op_i == OP_WR) ? cmd_wdata_i : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (per_ready_i) begin
                        if (poll_again) begin
                            poll_cnt <= poll_cnt + 1'b1;
                            // Zero gap re-issues immediately with the request held high
                            if (POLL_GAP != 0) begin
                                state       <= GAP;
                                per_valid_o <= 1'b0;
                                gap_cnt     <= '0;
                            end
                        end else begin
                            state         <= RESP;
                            per_valid_o   <= 1'b0;
                            per_we_o      <= 1'b0;
                            per_wdata_o   <= '0;
                            rsp_valid_o   <= 1'b1;
                            rsp_rdata_o   <= (op == OP_WR) ? 32'h0 : per_rdata_i;
                            rsp_timeout_o <= is_poll && !clear;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state       <= ACCESS;
                        per_valid_o <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRDB_CFG_MASTER_STATS_EN
    logic [15:0] txn_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txn_q <= '0;
        end else if (state == ACCESS && per_ready_i) begin
            txn_q <= txn_q + 16'd1;
        end
    end

    assign txn_count_o = txn_q;
`else
    assign txn_count_o = 16'h0;
`endif

    logic unused;
    assign unused = ^OP_RD;

endmodule

// File: doc/trdb_cfg_master.md
Name: trdb_cfg_master

Overview:
- Bus initiator that drives the trace debugger's memory-mapped register port (per_valid/per_we/per_addr/per_wdata -> per_ready/per_rdata).
- Converts a simple command stream (write, read, poll-until-clear) into single bus transfers and returns a response per command.
- Used by the boot/config sequencer and the debug bridge to program trace filters, issue DUMP writes, and wait for stream flush completion.

Parameters:
- APB_ADDR_WIDTH, 12, width of per_addr_o and cmd_addr_i
- POLL_MAX, 256, maximum bus reads per poll command before timeout (>=1)
- POLL_GAP, 4, idle cycles between consecutive poll reads (0 allowed)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  00=write, 01=read, 10=poll-until-clear, 11=reserved
- cmd_addr_i  in  APB_ADDR_WIDTH  register address
- cmd_wdata_i  in  32  write data; mask for poll
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  32  read data (0 for writes)
- rsp_timeout_o  out  1  poll timeout or reserved op
- per_valid_o  out  1  bus request
- per_we_o  out  1  bus write enable
- per_addr_o  out  APB_ADDR_WIDTH  bus address
- per_wdata_o  out  32  bus write data
- per_ready_i  in  1  bus transfer complete
- per_rdata_i  in  32  bus read data, valid in the completing cycle
- busy_o  out  1  high whenever state != IDLE
- txn_count_o  out  16  completed bus transfer count (optional feature)

Behaviour:
- Reset: state=IDLE; all outputs 0 except cmd_ready_o=1. Latched command, poll counter, and gap counter are cleared. Asserting reset mid-transfer abandons the transfer; no response is produced.
- States: IDLE, ACCESS, GAP, RESP.
- IDLE:
  - cmd_ready_o=1 only in IDLE.
  - On cmd_valid_i: latch op, addr, and wdata; clear poll_cnt.
  - Op 00/01/10 -> ACCESS.
  - Op 11 -> RESP with rdata=0 and timeout=1; no bus access.
- ACCESS:
  - per_valid_o=1; per_addr_o=latched addr.
  - per_we_o=1 only for write.
  - per_wdata_o=latched wdata for write, 0 otherwise.
  - All request signals are held stable until per_ready_i=1.
- Transfer completes in the cycle per_valid_o & per_ready_i:
  - write -> RESP, rdata=0, timeout=0.
  - read -> RESP, rdata=per_rdata_i, timeout=0.
  - poll, (per_rdata_i & mask)==0 -> RESP, rdata=per_rdata_i, timeout=0.
  - poll, not clear, poll_cnt==POLL_MAX-1 -> RESP, rdata=per_rdata_i, timeout=1.
  - poll, otherwise -> poll_cnt++; go to GAP (or straight back to ACCESS if POLL_GAP==0, leaving per_valid_o high).
- GAP: per_valid_o=0 for exactly POLL_GAP cycles, then ACCESS.
- RESP: rsp_valid_o=1; rsp_rdata_o and rsp_timeout_o held stable until rsp_ready_i. On acceptance -> IDLE, rsp_valid_o=0 in the next cycle.
- A new command is never accepted in the same cycle a response retires; back-to-back throughput is one command per 3 cycles minimum.
- Latency:
  - Command accepted in cycle N -> per_valid_o high in N+1.
  - With per_ready_i=1 in N+1 -> rsp_valid_o high in N+2.
- Mask 0 on poll: completes after the first read, timeout=0.
- POLL_MAX=1: a single read, then either clear or timeout.
- poll_cnt width is clog2(POLL_MAX)+1; it never wraps.

Optional Feature:
- Macro TRDB_CFG_MASTER_STATS_EN.
- Defined: txn_count_o is a 16-bit counter incremented on every completed bus transfer (each poll read counts). It wraps 0xFFFF->0x0000 and resets to 0.
- Undefined: txn_count_o tied to 0; no counter flops.
- All other behaviour is identical in both builds.

Test Plan:
- Write addr 0x0, data 0x0000_0013, per_ready_i=1 -> one bus cycle with per_we_o=1 and per_wdata_o=0x13; rsp_valid_o 2 cycles after accept, rdata=0, timeout=0.
- Read addr 0x4, per_ready_i low 3 cycles then high with per_rdata_i=0xDEAD_BEEF -> request held stable 4 cycles; rsp_rdata_o=0xDEADBEEF.
- Poll addr 0x4, mask 0x1; slave returns 0x1 twice then 0x0; POLL_GAP=4 -> 3 bus reads separated by 4 idle cycles; rsp rdata=0, timeout=0.
- Poll mask 0x1, slave always 0x1, POLL_MAX=256 -> exactly 256 reads, then rsp_timeout_o=1 and rsp_rdata_o=0x1.
- Op 11, then rsp_ready_i held low 5 cycles -> no per_valid_o; rsp_valid_o held with timeout=1; cmd_ready_o=0 until the response is accepted.
- Reset asserted during ACCESS of a read -> all outputs 0 immediately, cmd_ready_o=1 after release, no response. With STATS_EN: 3 writes plus a 3-read poll -> txn_count_o=6.
